pe_array: RTL
=============

Name: pe_array

Overview:
Parametrised convolution processing-element array and the successor to the fixed 4-PE, 8-bit datapath.
- NUM_PE lanes share one broadcast input window; each lane holds its own KLEN-tap filter.
- Each lane runs a sequential multiply-accumulate over the window, scales the result and packs PACK results per lane into an output word.
- Sits between the picture buffer (upstream, valid/ready) and the OFM memories (downstream, valid/ready).

Parameters:
NUM_PE, 4, number of parallel lanes (filters)
DATA_W, 8, pixel, weight and result width in bits
KLEN, 16, taps per window (power of two, >=2)
TAP_W, 4, tap index width = log2(KLEN)
ACC_W, 20, accumulator width; must be >= 2*DATA_W+TAP_W
SHIFT, 0, right shift applied to the accumulator before narrowing
PACK, 4, results packed per lane per output word (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
filter_we  in  NUM_PE  per-lane filter write enable (multi-hot allowed)
filter_addr  in  TAP_W  tap index to write
filter_data  in  DATA_W  unsigned weight
pic_valid  in  1  input window valid
pic  in  KLEN*DATA_W  window; tap t at bits [t*DATA_W +: DATA_W]
pic_ready  out  1  window accepted when pic_valid&&pic_ready
flush  in  1  emit a partially filled pack
res_valid  out  1  output word valid
res_data  out  NUM_PE*PACK*DATA_W  lane p, slot s at [(p*PACK+s)*DATA_W +: DATA_W]
res_ready  in  1  downstream accepts word
busy  out  1  high in MAC or DONE state

Behaviour:
- Reset (async, active-high): state=IDLE, all filters=0, accumulators=0, tap counter=0, pack_cnt=0, res_data=0, res_valid=0, busy=0. pic_ready is forced 0 while rst is high.
- FSM:
  - IDLE: pic_ready = !res_valid. On accept, latch pic into the window register, clear accumulators and the tap counter, go to MAC.
  - MAC: each cycle every lane adds win[t]*filt[p][t] (unsigned, zero-extended to ACC_W); t increments. After t=KLEN-1, go to DONE. Exactly KLEN cycles.
  - DONE: one cycle. Each lane writes r = narrow(acc>>SHIFT) into slot pack_cnt. If pack_cnt==PACK-1, set res_valid=1 and pack_cnt=0; otherwise pack_cnt+1. Return to IDLE.
- narrow(): keep the low DATA_W bits (truncation).
- Latency: res_valid (when the pack completes) is high on the edge KLEN+1 cycles after the accept edge. Minimum accept-to-accept spacing is KLEN+2 cycles.
- Output handshake:
  - res_valid and res_data stay stable until res_valid&&res_ready.
  - On that edge res_valid=0 and all slots clear to 0.
  - pic_ready stays low while res_valid is high, so no result is ever dropped.
- Flush: in IDLE with pack_cnt>0, !res_valid and flush=1, set res_valid=1 and pack_cnt=0. Unfilled slots read 0. Flush with pack_cnt==0 is ignored. Flush outside IDLE is ignored (it is not remembered).
- Filter writes:
  - Committed only in IDLE; writes in MAC or DONE are ignored.
  - A write on the same edge as a window accept is committed, and the new weight is used by that window.
  - filter_we=0 leaves filters unchanged.
- Simultaneous accept of an output word (res_ready) and a new window in IDLE cannot happen, because pic_ready is low while res_valid is high. The window is accepted the cycle after.
- Reset mid-MAC or mid-DONE aborts the window; no partial result is emitted.
- No overflow is possible inside ACC_W when ACC_W meets the parameter rule.

Optional Feature:
Macro PE_ARRAY_SATURATE_EN.
- Defined: narrow() saturates. If (acc>>SHIFT) >= 2^DATA_W, the result is 2^DATA_W-1; otherwise the low DATA_W bits.
- Undefined: plain truncation as described above.
- All other timing is identical.

Test Plan:
- Defaults. Load all filters with 1 (each lane at taps 0..15), one window of all 2s, PACK=1 build -> res_valid 17 cycles after accept, every lane = 0x20. With SHIFT=2 -> 0x08.
- Lanes differ. Lane p filter = p+1, window all 3s -> lane results 0x30, 0x60, 0x90, 0xC0. Four windows fill the pack (PACK=4), res_valid rises after the fourth DONE, pic_ready stays low until res_ready.
- Overflow. Filters all 0xFF, window all 0xFF (acc=0xFE010) -> 0x10 without PE_ARRAY_SATURATE_EN, 0xFF with it.
- Backpressure and flush.
  - Hold res_ready=0 for 10 cycles with a word pending -> res_data stable and no window accepted despite pic_valid=1.
  - After 2 windows, pulse flush in IDLE -> slots 0,1 hold results, slots 2,3 = 0.
- Filter write during MAC. Write filter_data=0x07 at tap 0 mid-MAC -> ignored; the same write in IDLE -> used by the next window.
- Reset mid-MAC. Assert rst at tap 8 -> res_valid=0, pack_cnt=0, filters=0, pic_ready=0 during reset and 1 on the first cycle after release.

Source files
------------

// File: rtl/pe_array_if.sv
// Handshake/bus bundle between picture buffer, pe_array and OFM memories.
// Latency: none (wires only). Backpressure: pic_ready / res_ready valid-ready pairs.
interface pe_array_if #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 8,
    parameter int KLEN   = 16,
    parameter int TAP_W  = 4,
    parameter int PACK   = 4
) ();
    logic [NUM_PE-1:0]             filter_we;
    logic [TAP_W-1:0]              filter_addr;
    logic [DATA_W-1:0]             filter_data;
    logic                          pic_valid;
    logic [KLEN*DATA_W-1:0]        pic;
    logic                          pic_ready;
    logic                          flush;
    logic                          res_valid;
    logic [NUM_PE*PACK*DATA_W-1:0] res_data;
    logic                          res_ready;
    logic                          busy;

    modport master (
        output filter_we, filter_addr, filter_data, pic_valid, pic, flush, res_ready,
        input  pic_ready, res_valid, res_data, busy
    );

    modport slave (
        input  filter_we, filter_addr, filter_data, pic_valid, pic, flush, res_ready,
        output pic_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/pe_array.sv
// NUM_PE-lane convolution PE array: shared window, per-lane KLEN-tap filters, packed outputs.
// Latency: res_valid rises KLEN+1 cycles after the accept edge of the window that fills the pack.
// Backpressure: pic_ready held low while a word is pending; PE_ARRAY_SATURATE_EN saturates results.
module pe_array #(
    parameter int NUM_PE = 4,
    parameter int DATA_W = 8,
    parameter int KLEN   = 16,
    parameter int TAP_W  = 4,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 0,
    parameter int PACK   = 4
) (
    input  logic      clk,
    input  logic      rst,
    pe_array_if.slave io
);
    localparam int PC_W = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [TAP_W-1:0]  tap;
    logic [PC_W-1:0]   pack_cnt;
    logic              res_valid;
    logic [DATA_W-1:0] win  [KLEN];
    logic [DATA_W-1:0] filt [NUM_PE][KLEN];
    logic [ACC_W-1:0]  acc  [NUM_PE];
    logic [ACC_W-1:0]  prod [NUM_PE];
    logic [DATA_W-1:0] slot [NUM_PE][PACK];
    logic [NUM_PE*PACK*DATA_W-1:0] res_flat;
    logic              idle;
    logic              accept;
    logic              flush_fire;

    function automatic logic [DATA_W-1:0] narrow(input logic [ACC_W-1:0] a);
`ifdef PE_ARRAY_SATURATE_EN
        logic [ACC_W-1:0] s;
        s = a >> SHIFT;
        if (|(s >> DATA_W))
            return '1;
        return s[DATA_W-1:0];
`else
        return DATA_W'(a >> SHIFT);
`endif
    endfunction

    assign idle         = (state == S_IDLE);
    assign io.pic_ready = idle && !res_valid && !rst;
    assign accept       = io.pic_valid && io.pic_ready;
    // An accept in the same cycle wins; the flush request is simply dropped.
    assign flush_fire   = idle && !res_valid && io.flush && (pack_cnt != '0) && !accept;
    assign io.res_valid = res_valid;
    assign io.busy      = (state == S_MAC) || (state == S_DONE);
    assign io.res_data  = res_flat;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++)
            prod[p] = ACC_W'({{DATA_W{1'b0}}, win[tap]} * {{DATA_W{1'b0}}, filt[p][tap]});
    end

    always_comb begin
        res_flat = '0;
        for (int p = 0; p < NUM_PE; p++)
            for (int s = 0; s < PACK; s++)
                res_flat[(p*PACK+s)*DATA_W +: DATA_W] = slot[p][s];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tap   <= '0;
            for (int t = 0; t < KLEN; t++)
                win[t] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_MAC;
                        tap   <= '0;
                        for (int t = 0; t < KLEN; t++)
                            win[t] <= io.pic[t*DATA_W +: DATA_W];
                    end
                end
                S_MAC: begin
                    tap <= tap + TAP_W'(1);
                    if (tap == TAP_W'(KLEN-1))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Weights only change while idle, so a window never sees a half-updated filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PE; p++)
                for (int t = 0; t < KLEN; t++)
                    filt[p][t] <= '0;
        end else if (idle) begin
            for (int p = 0; p < NUM_PE; p++)
                if (io.filter_we[p])
                    filt[p][io.filter_addr] <= io.filter_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PE; p++)
                acc[p] <= '0;
        end else if (accept) begin
            for (int p = 0; p < NUM_PE; p++)
                acc[p] <= '0;
        end else if (state == S_MAC) begin
            for (int p = 0; p < NUM_PE; p++)
                acc[p] <= acc[p] + prod[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_cnt  <= '0;
            res_valid <= 1'b0;
            for (int p = 0; p < NUM_PE; p++)
                for (int s = 0; s < PACK; s++)
                    slot[p][s] <= '0;
        end else begin
            if (res_valid && io.res_ready) begin
                res_valid <= 1'b0;
                for (int p = 0; p < NUM_PE; p++)
                    for (int s = 0; s < PACK; s++)
                        slot[p][s] <= '0;
            end
            // DONE never coincides with a pending word: no window starts while res_valid is high.
            if (state == S_DONE) begin
                for (int p = 0; p < NUM_PE; p++)
                    slot[p][pack_cnt] <= narrow(acc[p]);
                if (pack_cnt == PC_W'(PACK-1)) begin
                    res_valid <= 1'b1;
                    pack_cnt  <= '0;
                end else begin
                    pack_cnt <= pack_cnt + PC_W'(1);
                end
            end else if (flush_fire) begin
                res_valid <= 1'b1;
                pack_cnt  <= '0;
            end
        end
    end
endmodule
